// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: run/stop and half-period controller for a programmable clock divider.
// Period updates come in over a valid/ready handshake and take effect only where
// clockOut falls (or straight away while idle), so the output never glitches.
// Stopping waits for clockOut to be low.
module clock_div_ctrl #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned DEFAULT_PERIOD = 3
) (
   input  logic             clockIn,
   input  logic             resetN,
   input  logic             run,
   input  logic [WIDTH-1:0] periodIn,
   input  logic             periodValid,
   output logic             periodReady,
   output logic             clockOut,
   output logic             tick,
   output logic [WIDTH-1:0] activePeriod,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_PER   = WIDTH'(DEFAULT_PERIOD);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             pend_q, pend_d;
   logic             ready_q, ready_d;

   logic             xfer;
   logic [WIDTH-1:0] req_period;
   logic             at_end;

   // Handshake qualifier, zero-period mapping and end-of-half detection.
   always_comb begin
      xfer       = periodValid & ready_q;
      req_period = (periodIn == '0) ? ONE : periodIn;
      at_end     = (count_q == (active_q - ONE));
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clockIn or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         count_q   <= '0;
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
         active_q  <= RST_PER;
         pending_q <= '0;
         pend_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         ready_q   <= ready_d;
      end
   end

   // Next-state logic: divider counting, stop handling and period apply points.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      ready_d   = ready_q;

      // An idle-time update is loaded directly, leaving nothing outstanding;
      // ready then comes back on its own one cycle later.
      if (!ready_q && !pend_q) begin
         ready_d = 1'b1;
      end

      if (xfer) begin
         pending_d = req_period;
         pend_d    = 1'b1;
         ready_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            clk_d   = 1'b0;
            count_d = '0;
            if (xfer) begin
               // Applied at once so a RUN entered on this same edge uses it.
               active_d = req_period;
               pend_d   = 1'b0;
            end else if (pend_q) begin
               // Update left over from before the stop.
               active_d = pending_q;
               pend_d   = 1'b0;
               ready_d  = 1'b1;
            end
            if (run) begin
               state_d = RUN;
            end
         end

         RUN: begin
            count_d = count_q + ONE;
            if (at_end) begin
               count_d = '0;
               clk_d   = ~clk_q;
               if (!clk_q) begin
                  tick_d = 1'b1;
               end else if (pend_q) begin
                  active_d = pending_q;
                  pend_d   = 1'b0;
                  ready_d  = 1'b1;
               end
            end
            if (!run) begin
               if (!clk_q) begin
                  // Low half may be cut short; no rise is allowed to escape.
                  state_d = IDLE;
                  count_d = '0;
                  clk_d   = 1'b0;
                  tick_d  = 1'b0;
               end else if (at_end) begin
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            // clockOut is high here; finish the high half, then stop.
            count_d = count_q + ONE;
            if (at_end) begin
               count_d = '0;
               clk_d   = 1'b0;
               state_d = IDLE;
               if (pend_q) begin
                  active_d = pending_q;
                  pend_d   = 1'b0;
                  ready_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            count_d = '0;
            clk_d   = 1'b0;
         end
      endcase
   end

   assign clockOut     = clk_q;
   assign tick         = tick_q;
   assign activePeriod = active_q;
   assign periodReady  = ready_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl: directed bench for clock_div_ctrl with hand-derived expectations.
// Inputs change on the falling clockIn edge, outputs are sampled there too.
module tb_clock_div_ctrl;

   localparam int unsigned W = 16;

   logic         clk;
   logic         resetN;
   logic         run;
   logic [W-1:0] periodIn;
   logic         periodValid;
   logic         periodReady;
   logic         clockOut;
   logic         tick;
   logic [W-1:0] activePeriod;
   logic         busy;

   int checks = 0;
   int errors = 0;

   clock_div_ctrl #(
      .WIDTH          (W),
      .DEFAULT_PERIOD (3)
   ) dut (
      .clockIn      (clk),
      .resetN       (resetN),
      .run          (run),
      .periodIn     (periodIn),
      .periodValid  (periodValid),
      .periodReady  (periodReady),
      .clockOut     (clockOut),
      .tick         (tick),
      .activePeriod (activePeriod),
      .busy         (busy)
   );

   // Free-running 10 ns system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait one cycle, then check the divider outputs.
   task automatic cyc(input logic ec, input logic et, input logic eb,
                      input logic [W-1:0] ea, input string tag);
      @(negedge clk);
      chk({tag, "_clk"},  32'(clockOut),     32'(ec));
      chk({tag, "_tick"}, 32'(tick),         32'(et));
      chk({tag, "_busy"}, 32'(busy),         32'(eb));
      chk({tag, "_per"},  32'(activePeriod), 32'(ea));
   endtask

   // A running half of n cycles at level ec; a high half starts with a tick.
   task automatic halfc(input int n, input logic ec, input logic [W-1:0] ea, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc(ec, ec && (i == 0), 1'b1, ea, tag);
      end
   endtask

   // Directed sequence.
   initial begin
      resetN      = 1'b0;
      run         = 1'b0;
      periodIn    = '0;
      periodValid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_clk",   32'(clockOut),     32'd0);
      chk("rst_tick",  32'(tick),         32'd0);
      chk("rst_per",   32'(activePeriod), 32'd3);
      chk("rst_ready", 32'(periodReady),  32'd1);
      chk("rst_busy",  32'(busy),         32'd0);
      resetN = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Start at default period: rise after 4 cycles, then 3/3.
      run = 1'b1;
      halfc(3, 1'b0, 3, "t1_lo0");
      halfc(3, 1'b1, 3, "t1_hi");
      halfc(3, 1'b0, 3, "t1_lo");
      cyc(1'b1, 1'b1, 1'b1, 3, "t1_hi2");

      // Stop sampled in the 2nd high cycle: drain the high half, then idle.
      cyc(1'b1, 1'b0, 1'b1, 3, "t3_hi2nd");
      run = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, 3, "t3_drain");
      cyc(1'b0, 1'b0, 1'b0, 3, "t3_idle");
      repeat (6) cyc(1'b0, 1'b0, 1'b0, 3, "t3_stay");

      // Restart, then request period 5 in the first high cycle.
      run = 1'b1;
      halfc(3, 1'b0, 3, "t2_lo0");
      cyc(1'b1, 1'b1, 1'b1, 3, "t2_rise");
      periodValid = 1'b1;
      periodIn    = 16'd5;
      cyc(1'b1, 1'b0, 1'b1, 3, "t2_hi1");
      chk("t2_ready_lo1", 32'(periodReady), 32'd0);
      periodValid = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, 3, "t2_hi2");
      chk("t2_ready_lo2", 32'(periodReady), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 5, "t2_fall");
      chk("t2_ready_back", 32'(periodReady), 32'd1);
      halfc(4, 1'b0, 5, "t2_lo5");
      halfc(5, 1'b1, 5, "t2_hi5");

      // Held request of 7, first transfer coincident with a falling toggle.
      halfc(5, 1'b0, 5, "t5_lo5");
      halfc(4, 1'b1, 5, "t5_hi5");
      cyc(1'b1, 1'b0, 1'b1, 5, "t5_hilast");
      periodValid = 1'b1;
      periodIn    = 16'd7;
      cyc(1'b0, 1'b0, 1'b1, 5, "t5_fall_noapply");
      chk("t5_ready_xfer1", 32'(periodReady), 32'd0);
      halfc(4, 1'b0, 5, "t5_lo5b");
      halfc(5, 1'b1, 5, "t5_hi5b");
      cyc(1'b0, 1'b0, 1'b1, 7, "t5_apply1");
      chk("t5_ready_apply1", 32'(periodReady), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 7, "t5_lo7_1");
      chk("t5_ready_xfer2", 32'(periodReady), 32'd0);
      halfc(5, 1'b0, 7, "t5_lo7");
      halfc(7, 1'b1, 7, "t5_hi7");
      chk("t5_ready_held", 32'(periodReady), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 7, "t5_apply2");
      chk("t5_ready_apply2", 32'(periodReady), 32'd1);
      periodValid = 1'b0;
      run         = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 7, "t5_stop");
      chk("t5_ready_idle", 32'(periodReady), 32'd1);

      // Idle update of 0 maps to 1, then run at clockIn/2.
      periodValid = 1'b1;
      periodIn    = 16'd0;
      cyc(1'b0, 1'b0, 1'b0, 1, "t4_xfer");
      chk("t4_ready_lo", 32'(periodReady), 32'd0);
      periodValid = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1, "t4_ack");
      chk("t4_ready_back", 32'(periodReady), 32'd1);
      run = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1, "t4_run");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1, "t4_hi");
         cyc(1'b0, 1'b0, 1'b1, 1, "t4_lo");
      end
      cyc(1'b1, 1'b1, 1'b1, 1, "t4_hi_last");

      // Asynchronous reset pulse in the middle of a high half.
      #1;
      resetN = 1'b0;
      run    = 1'b0;
      #1;
      chk("t6_clk",   32'(clockOut),     32'd0);
      chk("t6_tick",  32'(tick),         32'd0);
      chk("t6_per",   32'(activePeriod), 32'd3);
      chk("t6_ready", 32'(periodReady),  32'd1);
      chk("t6_busy",  32'(busy),         32'd0);
      #1;
      resetN = 1'b1;
      @(negedge clk);
      chk("t6_idle_busy", 32'(busy),     32'd0);
      chk("t6_idle_clk",  32'(clockOut), 32'd0);
      run = 1'b1;
      halfc(3, 1'b0, 3, "t6_lo0");
      halfc(3, 1'b1, 3, "t6_hi");
      cyc(1'b0, 1'b0, 1'b1, 3, "t6_lo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
